// File: rtl/noc_pkg.sv
// Shared types and helpers for the RN request-side NoC injection stage.
package noc_pkg;

  localparam int unsigned NOC_PLW  = 82;
  localparam int unsigned NOC_TGTW = 2;

  typedef enum logic [1:0] {
    CH_AW = 2'd0,
    CH_W  = 2'd1,
    CH_AR = 2'd2
  } chan_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    HOLD   = 2'd1,
    WBURST = 2'd2
  } inj_state_e;

  // Round-robin successor: AW -> W -> AR -> AW.
  function automatic chan_e next_chan(input chan_e c);
    return (c == CH_AR) ? CH_AW : chan_e'(2'(c) + 2'd1);
  endfunction

  // First channel with a pending flit, scanning from the rr pointer.
  function automatic chan_e rr_pick(input chan_e rr, input logic [2:0] ne);
    chan_e c;
    chan_e pick;
    logic  found;
    c     = rr;
    pick  = rr;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && ne[c]) begin
        pick  = c;
        found = 1'b1;
      end
      c = next_chan(c);
    end
    return pick;
  endfunction

endpackage

// File: rtl/rn_flit_fifo.sv
// Synchronous flit FIFO with wrap-bit pointers; full blocks push, no bypass.
module rn_flit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rn_noc_inject.sv
// Buffers AW/W/AR request flits and round-robins them onto the router local port,
// keeping W bursts contiguous.
module rn_noc_inject
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PLW   = NOC_PLW,
  parameter int unsigned TGTW  = NOC_TGTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            aw_valid,
  output logic            aw_ready,
  input  logic [PLW-1:0]  aw_payload,
  input  logic [TGTW-1:0] aw_tgtid,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic            w_head,
  input  logic            w_tail,
  input  logic [PLW-1:0]  w_payload,
  input  logic [TGTW-1:0] w_tgtid,
  input  logic            ar_valid,
  output logic            ar_ready,
  input  logic [PLW-1:0]  ar_payload,
  input  logic [TGTW-1:0] ar_tgtid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_type,
  output logic            out_head,
  output logic            out_tail,
  output logic [PLW-1:0]  out_payload,
  output logic [TGTW-1:0] out_tgtid,
  output logic            err_w_orphan
);

  localparam int unsigned AW_W = PLW + TGTW;
  localparam int unsigned WW_W = PLW + TGTW + 2;

  logic            aw_full, aw_empty, aw_pop;
  logic            w_full, w_empty, w_pop;
  logic            ar_full, ar_empty, ar_pop;
  logic [AW_W-1:0] aw_dout, ar_dout;
  logic [WW_W-1:0] w_dout;
  logic [2:0]      ne;

  inj_state_e state;
  chan_e      rr;
  chan_e      hold_ch;
  chan_e      cur_ch;
  logic       transfer;
  logic       wq_head, wq_tail;

  assign aw_ready = !rst && !aw_full;
  assign w_ready  = !rst && !w_full;
  assign ar_ready = !rst && !ar_full;

  rn_flit_fifo #(.DEPTH(DEPTH), .W(AW_W)) u_aw_fifo (
    .clk(clk), .rst(rst), .push(aw_valid && aw_ready), .din({aw_tgtid, aw_payload}),
    .pop(aw_pop), .dout(aw_dout), .full(aw_full), .empty(aw_empty)
  );

  rn_flit_fifo #(.DEPTH(DEPTH), .W(WW_W)) u_w_fifo (
    .clk(clk), .rst(rst), .push(w_valid && w_ready),
    .din({w_head, w_tail, w_tgtid, w_payload}),
    .pop(w_pop), .dout(w_dout), .full(w_full), .empty(w_empty)
  );

  rn_flit_fifo #(.DEPTH(DEPTH), .W(AW_W)) u_ar_fifo (
    .clk(clk), .rst(rst), .push(ar_valid && ar_ready), .din({ar_tgtid, ar_payload}),
    .pop(ar_pop), .dout(ar_dout), .full(ar_full), .empty(ar_empty)
  );

  assign ne      = {!ar_empty, !w_empty, !aw_empty};
  assign wq_head = w_dout[WW_W-1];
  assign wq_tail = w_dout[WW_W-2];

  // Grant selection and output mux; everything here derives from registered state.
  always_comb begin
    cur_ch      = rr_pick(rr, ne);
    out_valid   = |ne;
    out_type    = 2'(CH_AW);
    out_head    = 1'b1;
    out_tail    = 1'b1;
    out_payload = aw_dout[PLW-1:0];
    out_tgtid   = aw_dout[AW_W-1:PLW];
    case (state)
      HOLD: begin
        cur_ch    = hold_ch;
        out_valid = ne[hold_ch];
      end
      WBURST: begin
        cur_ch    = CH_W;
        out_valid = ne[CH_W];
      end
      default: ;
    endcase
    out_type = 2'(cur_ch);
    case (cur_ch)
      CH_W: begin
        out_head    = wq_head;
        out_tail    = wq_tail;
        out_payload = w_dout[PLW-1:0];
        out_tgtid   = w_dout[AW_W-1:PLW];
      end
      CH_AR: begin
        out_payload = ar_dout[PLW-1:0];
        out_tgtid   = ar_dout[AW_W-1:PLW];
      end
      default: ;
    endcase
  end

  assign transfer = out_valid && out_ready;
  assign aw_pop   = transfer && (cur_ch == CH_AW);
  assign w_pop    = transfer && (cur_ch == CH_W);
  assign ar_pop   = transfer && (cur_ch == CH_AR);

  // FSM: a W flit without tail keeps the W lock; any other transfer re-arbitrates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      rr           <= CH_AW;
      hold_ch      <= CH_AW;
      err_w_orphan <= 1'b0;
    end else begin
      if (transfer) begin
        if (cur_ch == CH_W && !wq_tail) begin
          state <= WBURST;
        end else begin
          state <= ARB;
          rr    <= next_chan(cur_ch);
        end
        if (cur_ch == CH_W && !wq_head && state != WBURST) err_w_orphan <= 1'b1;
      end else if (state == ARB && out_valid) begin
        state   <= HOLD;
        hold_ch <= cur_ch;
      end
    end
  end

endmodule

// File: tb/tb_rn_noc_inject.sv
// Scoreboard bench: directed pushes queue hand-ordered expected flits; a negedge
// monitor compares every router-side transfer against the queue head.
module tb_rn_noc_inject;

  localparam int PLW = 82;

  typedef struct packed {
    logic [1:0]     typ;
    logic           head;
    logic           tail;
    logic [1:0]     tgt;
    logic [PLW-1:0] pl;
  } flit_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
  logic           aw_ready, w_ready, ar_ready;
  logic [PLW-1:0] aw_payload = '0, w_payload = '0, ar_payload = '0;
  logic [1:0]     aw_tgtid = '0, w_tgtid = '0, ar_tgtid = '0;
  logic           w_head = 1'b0, w_tail = 1'b0;
  logic           out_valid, out_head, out_tail, err_w_orphan;
  logic           out_ready = 1'b0;
  logic [1:0]     out_type, out_tgtid;
  logic [PLW-1:0] out_payload;

  int    checks = 0;
  int    errors = 0;
  flit_t sb[$];

  always #5 clk = ~clk;

  rn_noc_inject dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_payload(aw_payload), .aw_tgtid(aw_tgtid),
    .w_valid(w_valid), .w_ready(w_ready), .w_head(w_head), .w_tail(w_tail),
    .w_payload(w_payload), .w_tgtid(w_tgtid),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_payload(ar_payload), .ar_tgtid(ar_tgtid),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_head(out_head), .out_tail(out_tail), .out_payload(out_payload),
    .out_tgtid(out_tgtid), .err_w_orphan(err_w_orphan)
  );

  // Monitor: every accepted flit must match the oldest expectation.
  always @(negedge clk) begin
    flit_t act, e;
    if (!rst && out_valid && out_ready) begin
      act = {out_type, out_head, out_tail, out_tgtid, out_payload};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL flit_unexpected: got %0h required none", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL flit: got %0h required %0h", act, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic exp_flit(input logic [1:0] typ, input logic h, input logic t,
                          input logic [1:0] tg, input logic [PLW-1:0] p);
    flit_t f;
    f.typ = typ; f.head = h; f.tail = t; f.tgt = tg; f.pl = p;
    sb.push_back(f);
  endtask

  task automatic set_aw(input logic [1:0] t, input logic [PLW-1:0] p);
    aw_valid = 1'b1; aw_tgtid = t; aw_payload = p;
  endtask

  task automatic set_w(input logic h, input logic tl, input logic [1:0] t,
                       input logic [PLW-1:0] p);
    w_valid = 1'b1; w_head = h; w_tail = tl; w_tgtid = t; w_payload = p;
  endtask

  task automatic set_ar(input logic [1:0] t, input logic [PLW-1:0] p);
    ar_valid = 1'b1; ar_tgtid = t; ar_payload = p;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check({name, "_drained"}, 128'(sb.size()), 128'd0);
    check({name, "_idle"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    check("rst_aw_ready", 128'(aw_ready), 128'd0);
    check("rst_w_ready", 128'(w_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_err", 128'(err_w_orphan), 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("post_rst_readies", 128'({aw_ready, w_ready, ar_ready}), 128'd7);

    // Single AW, one-cycle latency
    out_ready = 1'b1;
    set_aw(2'd2, 82'h100);
    exp_flit(2'd0, 1'b1, 1'b1, 2'd2, 82'h100);
    tick();
    check("t1_latency_valid", 128'(out_valid), 128'd1);
    check("t1_type", 128'(out_type), 128'd0);
    drain("t1");

    // Round-robin AW, W(single), AR, then AW again
    do_reset();
    out_ready = 1'b1;
    set_aw(2'd1, 82'h201); set_w(1'b1, 1'b1, 2'd3, 82'h202); set_ar(2'd0, 82'h203);
    exp_flit(2'd0, 1'b1, 1'b1, 2'd1, 82'h201);
    exp_flit(2'd1, 1'b1, 1'b1, 2'd3, 82'h202);
    exp_flit(2'd2, 1'b1, 1'b1, 2'd0, 82'h203);
    exp_flit(2'd0, 1'b1, 1'b1, 2'd2, 82'h204);
    tick();
    set_aw(2'd2, 82'h204);
    tick();
    drain("t2");

    // W burst with bubble; AR blocked until tail
    set_w(1'b1, 1'b0, 2'd1, 82'h301);
    exp_flit(2'd1, 1'b1, 1'b0, 2'd1, 82'h301);
    exp_flit(2'd1, 1'b0, 1'b0, 2'd1, 82'h302);
    exp_flit(2'd1, 1'b0, 1'b0, 2'd1, 82'h303);
    exp_flit(2'd1, 1'b0, 1'b1, 2'd1, 82'h304);
    exp_flit(2'd2, 1'b1, 1'b1, 2'd3, 82'h305);
    tick();
    set_w(1'b0, 1'b0, 2'd1, 82'h302); set_ar(2'd3, 82'h305);
    tick();
    tick();
    check("t3_bubble_valid", 128'(out_valid), 128'd0);
    set_w(1'b0, 1'b0, 2'd1, 82'h303);
    tick();
    set_w(1'b0, 1'b1, 2'd1, 82'h304);
    tick();
    drain("t3");
    check("t3_no_orphan", 128'(err_w_orphan), 128'd0);

    // AR held stable under backpressure while AW arrives
    out_ready = 1'b0;
    set_ar(2'd1, 82'h401);
    exp_flit(2'd2, 1'b1, 1'b1, 2'd1, 82'h401);
    exp_flit(2'd0, 1'b1, 1'b1, 2'd0, 82'h402);
    tick();
    set_aw(2'd0, 82'h402);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold", 128'({out_valid, out_type, out_payload}), {45'd0, 1'b1, 2'd2, 82'h401});
      tick();
    end
    drain("t4");

    // Fill AW FIFO, backpressure, single pop frees a slot
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_aw_ready_fill", 128'(aw_ready), 128'd1);
      set_aw(2'(i), 82'h500 + 82'(i));
      exp_flit(2'd0, 1'b1, 1'b1, 2'(i), 82'h500 + 82'(i));
      tick();
    end
    check("t5_aw_full", 128'(aw_ready), 128'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t5_aw_ready_after_pop", 128'(aw_ready), 128'd1);
    drain("t5");

    // Reset mid-burst flushes lock; then orphan W sets sticky error
    do_reset();
    out_ready = 1'b1;
    set_w(1'b1, 1'b0, 2'd2, 82'h601);
    exp_flit(2'd1, 1'b1, 1'b0, 2'd2, 82'h601);
    tick();
    set_w(1'b0, 1'b0, 2'd2, 82'h602);
    tick();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t6_flushed", 128'(out_valid), 128'd0);
    check("t6_sb_after_rst", 128'(sb.size()), 128'd0);
    set_aw(2'd3, 82'h603);
    exp_flit(2'd0, 1'b1, 1'b1, 2'd3, 82'h603);
    tick();
    drain("t6_aw");
    check("t6_err_clear", 128'(err_w_orphan), 128'd0);
    set_w(1'b0, 1'b1, 2'd1, 82'h604);
    exp_flit(2'd1, 1'b0, 1'b1, 2'd1, 82'h604);
    tick();
    drain("t6_orphan");
    check("t6_err_set", 128'(err_w_orphan), 128'd1);
    set_ar(2'd2, 82'h605);
    exp_flit(2'd2, 1'b1, 1'b1, 2'd2, 82'h605);
    tick();
    drain("t6_ar");
    check("t6_err_sticky", 128'(err_w_orphan), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
